// File: rtl/ks_pkg.sv
// Shared sizing helpers for the pipelined Kogge-Stone adder.
// Legal WIDTH bounds and the level/group arithmetic live here so every file agrees.
package ks_pkg;

   localparam int KS_MIN_WIDTH = 4;
   localparam int KS_MAX_WIDTH = 64;

   function automatic int ks_levels(input int width);
      int l;
      l = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < width) l = i + 1;
      end
      return l;
   endfunction

   function automatic int ks_groups(input int levels, input int reg_every);
      return (levels + reg_every - 1) / reg_every;
   endfunction

   function automatic bit ks_is_pow2(input int width);
      return (width > 0) && ((width & (width - 1)) == 0);
   endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix row at span DIST: black cells for i >= DIST,
// plain pass-through below that.
module ks_prefix_level
   import ks_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
)(
   input  logic [WIDTH-1:0] i_p,
   input  logic [WIDTH-1:0] i_g,
   output logic [WIDTH-1:0] o_p,
   output logic [WIDTH-1:0] o_g
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi >= DIST) begin : g_cell
            assign o_g[gi] = i_g[gi] | (i_p[gi] & i_g[gi-DIST]);
            assign o_p[gi] = i_p[gi] & i_p[gi-DIST];
         end else begin : g_pass
            assign o_g[gi] = i_g[gi];
            assign o_p[gi] = i_p[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with elastic valid/ready stages.
// Stage 0 forms P/G, stages 1..NS-1 each run REG_EVERY prefix levels; the last also forms the sum.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int REG_EVERY = 2,
   parameter int TAG_W     = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int LEVELS = ks_levels(WIDTH);
   localparam int GROUPS = ks_groups(LEVELS, REG_EVERY);
   localparam int NS     = 1 + GROUPS;

   generate
      if (!ks_is_pow2(WIDTH) || WIDTH < KS_MIN_WIDTH || WIDTH > KS_MAX_WIDTH) begin : g_bad_width
         $error("ks_adder_pipe: WIDTH must be a power of two in 4..64");
      end
      if (REG_EVERY < 1 || REG_EVERY > LEVELS) begin : g_bad_reg_every
         $error("ks_adder_pipe: REG_EVERY must be in 1..log2(WIDTH)");
      end
   endgenerate

   // Stages 0..NS-2 hold working P/G; the final stage holds the finished result.
   logic [WIDTH-1:0] r_praw [NS-1];
   logic [WIDTH-1:0] r_p    [NS-1];
   logic [WIDTH-1:0] r_g    [NS-1];
   logic             r_c0   [NS-1];
   logic [TAG_W-1:0] r_tag  [NS-1];
   logic [NS-1:0]    r_v;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic [TAG_W-1:0] r_otag;

   logic [WIDTH-1:0] w_d_praw [NS-1];
   logic [WIDTH-1:0] w_d_p    [NS-1];
   logic [WIDTH-1:0] w_d_g    [NS-1];
   logic             w_d_c0   [NS-1];
   logic [TAG_W-1:0] w_d_tag  [NS-1];
   logic             w_up_v   [NS];
   logic             w_ready  [NS+1];

   logic [WIDTH-1:0] w_lin_p  [LEVELS];
   logic [WIDTH-1:0] w_lin_g  [LEVELS];
   logic [WIDTH-1:0] w_lout_p [LEVELS];
   logic [WIDTH-1:0] w_lout_g [LEVELS];

   logic [WIDTH-1:0] w_b;
   logic             w_c0;
   logic [WIDTH-1:0] w_p0;
   logic [WIDTH-1:0] w_g0;
   logic [WIDTH-1:0] w_gf;
   logic [WIDTH-1:0] w_carry;
   logic             w_unused_p;

   // Carry-in is folded into G_0 so the prefix tree alone yields every carry.
   assign w_b  = in_sub ? ~in_b : in_b;
   assign w_c0 = in_sub | in_cin;
   assign w_p0 = in_a ^ w_b;
   assign w_g0 = (in_a & w_b) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_c0};

   assign w_d_praw[0] = w_p0;
   assign w_d_p[0]    = w_p0;
   assign w_d_g[0]    = w_g0;
   assign w_d_c0[0]   = w_c0;
   assign w_d_tag[0]  = in_tag;
   assign w_up_v[0]   = in_valid;

   genvar gi;
   generate
      for (gi = 0; gi < LEVELS; gi++) begin : g_level
         if (gi % REG_EVERY == 0) begin : g_from_reg
            assign w_lin_p[gi] = r_p[gi / REG_EVERY];
            assign w_lin_g[gi] = r_g[gi / REG_EVERY];
         end else begin : g_from_comb
            assign w_lin_p[gi] = w_lout_p[gi-1];
            assign w_lin_g[gi] = w_lout_g[gi-1];
         end
         ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << gi)) u_level (
            .i_p (w_lin_p[gi]),
            .i_g (w_lin_g[gi]),
            .o_p (w_lout_p[gi]),
            .o_g (w_lout_g[gi])
         );
      end

      for (gi = 1; gi < NS - 1; gi++) begin : g_mid_stage
         assign w_d_praw[gi] = r_praw[gi-1];
         assign w_d_p[gi]    = w_lout_p[gi*REG_EVERY - 1];
         assign w_d_g[gi]    = w_lout_g[gi*REG_EVERY - 1];
         assign w_d_c0[gi]   = r_c0[gi-1];
         assign w_d_tag[gi]  = r_tag[gi-1];
      end

      for (gi = 1; gi < NS; gi++) begin : g_up_valid
         assign w_up_v[gi] = r_v[gi-1];
      end

      // A stage can take a beat if it is empty or its occupant moves on this cycle.
      assign w_ready[NS] = out_ready;
      for (gi = 0; gi < NS; gi++) begin : g_ready
         assign w_ready[gi] = ~r_v[gi] | w_ready[gi+1];
      end
   endgenerate

   assign w_gf       = w_lout_g[LEVELS-1];
   assign w_carry    = {w_gf[WIDTH-2:0], r_c0[NS-2]};
   assign w_unused_p = ^w_lout_p[LEVELS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         for (int s = 0; s < NS - 1; s++) begin
            r_praw[s] <= '0;
            r_p[s]    <= '0;
            r_g[s]    <= '0;
            r_c0[s]   <= 1'b0;
            r_tag[s]  <= '0;
         end
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_otag <= '0;
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (w_ready[s]) r_v[s] <= w_up_v[s];
         end
         for (int s = 0; s < NS - 1; s++) begin
            if (w_ready[s] && w_up_v[s]) begin
               r_praw[s] <= w_d_praw[s];
               r_p[s]    <= w_d_p[s];
               r_g[s]    <= w_d_g[s];
               r_c0[s]   <= w_d_c0[s];
               r_tag[s]  <= w_d_tag[s];
            end
         end
         if (w_ready[NS-1] && w_up_v[NS-1]) begin
            r_sum  <= r_praw[NS-2] ^ w_carry;
            r_cout <= w_gf[WIDTH-1];
            r_ovf  <= w_carry[WIDTH-1] ^ w_gf[WIDTH-1];
            r_otag <= r_tag[NS-2];
         end
      end
   end

   assign in_ready  = w_ready[0];
   assign out_valid = r_v[NS-1];
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;
   assign out_tag   = r_otag;

endmodule
